watchdog_timer_driver: RTL and testbench
========================================

WATCHDOG_TIMER_DRIVER -- requirements
Module: watchdog_timer_driver

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of the monitored data word.
REQ-002 The block SHALL have parameter PULSE_WIDTH, default 1: number of clock cycles delta stays high per detected change; legal range is 1 to 255.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_in, input, DATA_WIDTH bits: monitored value; sampled on every rising edge of clk.
REQ-006 The block SHALL have port delta, output, 1 bit: registered kick/activity pulse, high when a change of data_in has been detected.

Function
REQ-007 The block SHALL hold a previous-sample register prev_q, DATA_WIDTH bits, loaded with data_in on every rising clk edge while rstn is high.
REQ-008 The block SHALL declare a change at a rising edge when data_in differs from prev_q in any bit; the comparison covers the full DATA_WIDTH.
REQ-009 The block SHALL hold a pulse counter cnt_q, 8 bits, loaded with PULSE_WIDTH at an edge where a change is declared.
REQ-010 At an edge with no change, cnt_q SHALL decrement by 1 if nonzero and SHALL hold at 0 otherwise, with no wrap below 0.
REQ-011 The delta output SHALL be driven directly from a flop equal to (cnt_q != 0) after the edge, with no combinational path from data_in to delta.
REQ-012 Latency: a new value sampled at edge k SHALL make delta high from just after edge k through just before edge k+PULSE_WIDTH, provided no further change occurs.
REQ-013 Retrigger: a change declared while delta is high SHALL reload cnt_q to PULSE_WIDTH, extending the pulse; pulses SHALL NOT accumulate.
REQ-014 Consecutive changes on every edge SHALL keep delta continuously high.
REQ-015 A value held constant SHALL produce no further change detections.
REQ-016 The first sample after reset SHALL be compared against the reset value 0 of prev_q: a nonzero first sample asserts delta, and a zero first sample does not.
REQ-017 X/Z values on data_in are outside the operating range; the block SHALL NOT be required to filter them.

Reset
REQ-018 When rstn is low, prev_q, cnt_q and delta SHALL clear to 0 immediately, independent of clk, and SHALL remain 0 while rstn stays low.
REQ-019 Reset asserted mid-pulse SHALL drop delta to 0 at once; after release, detection SHALL restart per REQ-016.
REQ-020 The first rising edge after rstn deasserts SHALL perform a normal sample and compare.

Verification
REQ-021 Scenario: hold rstn=0 with data_in=0 for 3 cycles, then release and hold data_in=0 for 10 cycles -> delta=0 throughout.
REQ-022 Scenario: with PULSE_WIDTH=1, data_in changes 0 to 1000 before edge k and is then held -> delta=1 for exactly one cycle after edge k, then 0.
REQ-023 Scenario: data_in is 1000, 1001, 1002 on successive edges -> delta stays high across all three cycles and falls one cycle after the last change.
REQ-024 Scenario: data_in is 1001 then 1001 again -> delta is 1 after the first edge and 0 after the second.
REQ-025 Scenario: with PULSE_WIDTH=3, a change at edge k followed by a change at edge k+2 -> delta stays high through edge k+4 and is 0 after edge k+5.
REQ-026 Scenario: rstn pulsed low mid-pulse between clock edges -> delta goes 0 asynchronously; with data_in held at 1002 after release, delta=1 for PULSE_WIDTH cycles per REQ-016.

Source files
------------

// File: rtl/watchdog_timer_driver.sv
// Activity detector: pulses delta for PULSE_WIDTH cycles
// whenever the sampled data word changes.
module watchdog_timer_driver #(
  parameter int DATA_WIDTH  = 32,
  parameter int PULSE_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  delta
);

  localparam logic [7:0] PW = 8'(PULSE_WIDTH);

  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] prev_d;
  logic [7:0]            cnt_q;
  logic [7:0]            cnt_d;
  logic                  delta_q;
  logic                  delta_d;
  logic                  change;

  always_comb begin
    change  = (data_in != prev_q);
    prev_d  = data_in;
    cnt_d   = cnt_q;
    if (change) begin
      cnt_d = PW;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
    // registered so delta has no path from data_in
    delta_d = (cnt_d != 8'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q  <= '0;
      cnt_q   <= 8'd0;
      delta_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      delta_q <= delta_d;
    end
  end

  assign delta = delta_q;

endmodule

// File: tb/tb_watchdog_timer_driver.sv
// Bench: two instances (pulse width 1 and 3) checked against
// a cycles-since-last-change model and literal expectations.
module tb_watchdog_timer_driver;

  logic        clk;
  logic        rstn;
  logic [31:0] data_in;
  logic        delta1;
  logic        delta3;

  int n_chk;
  int n_fail;

  typedef struct {
    logic        r;
    logic [31:0] d;
    logic        e1;
    logic        e3;
    logic        ap;
  } vec_t;

  vec_t v[$];

  logic [31:0] m_last;
  int          m_since;

  watchdog_timer_driver #(
    .DATA_WIDTH (32),
    .PULSE_WIDTH(1)
  ) u_dut1 (
    .clk    (clk),
    .rstn   (rstn),
    .data_in(data_in),
    .delta  (delta1)
  );

  watchdog_timer_driver #(
    .DATA_WIDTH (32),
    .PULSE_WIDTH(3)
  ) u_dut3 (
    .clk    (clk),
    .rstn   (rstn),
    .data_in(data_in),
    .delta  (delta3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=%b expected=%b",
               nm, idx, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] d,
                     input logic e1, input logic e3,
                     input logic ap = 1'b0);
    vec_t t;
    t.r  = r;
    t.d  = d;
    t.e1 = e1;
    t.e3 = e3;
    t.ap = ap;
    v.push_back(t);
  endtask

  task automatic model_reset();
    m_last  = '0;
    m_since = 1000;
  endtask

  task automatic model_edge(input logic [31:0] d);
    if (d != m_last) m_since = 0;
    else if (m_since < 1000) m_since++;
    m_last = d;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    data_in = '0;
    model_reset();

    // reset held, then idle at zero
    repeat (3) add(1'b0, 0, 1'b0, 1'b0);
    repeat (10) add(1'b1, 0, 1'b0, 1'b0);
    // single change then hold
    add(1'b1, 1000, 1'b1, 1'b1);
    add(1'b1, 1000, 1'b0, 1'b1);
    add(1'b1, 1000, 1'b0, 1'b1);
    add(1'b1, 1000, 1'b0, 1'b0);
    add(1'b1, 1000, 1'b0, 1'b0);
    add(1'b1, 5, 1'b1, 1'b1);
    add(1'b1, 5, 1'b0, 1'b1);
    add(1'b1, 5, 1'b0, 1'b1);
    add(1'b1, 5, 1'b0, 1'b0);
    // back-to-back changes
    add(1'b1, 1000, 1'b1, 1'b1);
    add(1'b1, 1001, 1'b1, 1'b1);
    add(1'b1, 1002, 1'b1, 1'b1);
    add(1'b1, 1002, 1'b0, 1'b1);
    add(1'b1, 1002, 1'b0, 1'b1);
    add(1'b1, 1002, 1'b0, 1'b0);
    // repeated value
    add(1'b1, 1001, 1'b1, 1'b1);
    add(1'b1, 1001, 1'b0, 1'b1);
    add(1'b1, 1001, 1'b0, 1'b1);
    add(1'b1, 1001, 1'b0, 1'b0);
    // retrigger two edges apart
    add(1'b1, 7, 1'b1, 1'b1);
    add(1'b1, 7, 1'b0, 1'b1);
    add(1'b1, 8, 1'b1, 1'b1);
    add(1'b1, 8, 1'b0, 1'b1);
    add(1'b1, 8, 1'b0, 1'b1);
    add(1'b1, 8, 1'b0, 1'b0);
    add(1'b1, 8, 1'b0, 1'b0);
    // MSB-only difference
    add(1'b1, 32'h8000_0008, 1'b1, 1'b1);
    add(1'b1, 32'h8000_0008, 1'b0, 1'b1);
    add(1'b1, 32'h8000_0008, 1'b0, 1'b1);
    add(1'b1, 32'h8000_0008, 1'b0, 1'b0);
    // change every edge
    for (int i = 1; i <= 5; i++)
      add(1'b1, 32'(i), 1'b1, 1'b1);
    add(1'b1, 5, 1'b0, 1'b1);
    // synchronous-window reset, zero first sample
    add(1'b0, 0, 1'b0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b0);
    add(1'b1, 0, 1'b0, 1'b0);
    add(1'b1, 0, 1'b0, 1'b0);
    // async reset mid-pulse, then restart on 1002
    add(1'b1, 1002, 1'b1, 1'b1, 1'b1);
    add(1'b1, 1002, 1'b1, 1'b1);
    add(1'b1, 1002, 1'b0, 1'b1);
    add(1'b1, 1002, 1'b0, 1'b1);
    add(1'b1, 1002, 1'b0, 1'b0);
    add(1'b1, 1002, 1'b0, 1'b0);

    foreach (v[i]) begin
      @(negedge clk);
      rstn    = v[i].r;
      data_in = v[i].d;
      if (!rstn) begin
        #1;
        chk("rst_async_d1", i, delta1, 1'b0);
        chk("rst_async_d3", i, delta3, 1'b0);
      end
      @(posedge clk);
      if (!rstn) model_reset();
      else model_edge(data_in);
      #1;
      chk("model_d1", i, delta1, (m_since < 1));
      chk("model_d3", i, delta3, (m_since < 3));
      chk("lit_d1", i, delta1, v[i].e1);
      chk("lit_d3", i, delta3, v[i].e3);
      if (v[i].ap) begin
        #1 rstn = 1'b0;
        #1;
        chk("apulse_d1", i, delta1, 1'b0);
        chk("apulse_d3", i, delta3, 1'b0);
        model_reset();
        #1 rstn = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
